// File: rtl/text_row_scheduler_pkg.sv
// Shared definitions for the VGA text-row overlay.
//  - CODE_W_DEF : default character code width
//  - ROW_H/CELL_W : glyph cell geometry (16 lines x 8 pixels)
//  - fsm_state_t : prefetch sequencer states
//  - font_row() : glyph row within the text row; the font ROM address is {code, row}
package text_row_scheduler_pkg;

    localparam int unsigned CODE_W_DEF = 2;
    localparam int unsigned ROW_H      = 16;
    localparam int unsigned CELL_W     = 8;
    localparam int unsigned ROW_BITS   = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_BUF,
        ST_RD_ROM,
        ST_LATCH
    } fsm_state_t;

    function automatic logic [ROW_BITS-1:0] font_row(input logic [9:0] py, input logic [9:0] y0);
        return ROW_BITS'(py - y0);
    endfunction

endpackage

// File: rtl/text_row_scheduler_if.sv
// Host write port of the character buffer.
//  wr_en   : request, held high by the host until wr_ack
//  wr_idx  : target cell
//  wr_code : character code
//  wr_ack  : one-clk pulse once the write is committed (or dropped)
// master = host side, slave = scheduler side.
interface text_row_scheduler_if
    import text_row_scheduler_pkg::*;
#(
    parameter int unsigned CODE_W = CODE_W_DEF
);
    logic              wr_en;
    logic [3:0]        wr_idx;
    logic [CODE_W-1:0] wr_code;
    logic              wr_ack;

    modport master (output wr_en, wr_idx, wr_code, input wr_ack);
    modport slave  (input wr_en, wr_idx, wr_code, output wr_ack);
endinterface

// File: rtl/text_row_scheduler_char_buf.sv
// Character buffer: NCHARS x CODE_W register file.
//  clk, rst          : clock, synchronous active-high reset (clears contents)
//  we/wr_idx/wr_code : write port; indices >= NCHARS are ignored
//  rd_en/rd_idx      : read request
//  rd_code           : registered read data, valid the clk after rd_en
module text_row_scheduler_char_buf
    import text_row_scheduler_pkg::*;
#(
    parameter int unsigned NCHARS = 8,
    parameter int unsigned CODE_W = CODE_W_DEF,
    parameter int unsigned IW     = (NCHARS > 1) ? $clog2(NCHARS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [3:0]        wr_idx,
    input  logic [CODE_W-1:0] wr_code,
    input  logic              rd_en,
    input  logic [IW-1:0]     rd_idx,
    output logic [CODE_W-1:0] rd_code
);
    logic [CODE_W-1:0] mem [NCHARS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NCHARS; i++) begin
                mem[i] <= '0;
            end
            rd_code <= '0;
        end else begin
            if (we && (32'(wr_idx) < NCHARS)) begin
                mem[wr_idx[IW-1:0]] <= wr_code;
            end
            if (rd_en) begin
                rd_code <= mem[rd_idx];
            end
        end
    end
endmodule

// File: rtl/text_row_scheduler.sv
// Text-row scheduler: prefetches each cell's font row one cell ahead of the
// beam and produces gated r/g/b bits for the pixel pipeline.
//  clk, rst            : clock, synchronous active-high reset
//  pix_tick            : one-clk pixel strobe (period >= 4 clk)
//  pixel_x/pixel_y     : beam position, valid at pix_tick
//  video_on            : visible-area flag, valid at pix_tick
//  R, G, B             : text colour
//  host                : character buffer write port (slave side)
//  rom_addr/font_word  : external font ROM, 1-clk synchronous read
//  busy                : prefetch in flight
//  r, g, b             : pixel colour, registered on pix_tick
module text_row_scheduler
    import text_row_scheduler_pkg::*;
#(
    parameter int unsigned NCHARS = 8,
    parameter int unsigned CODE_W = CODE_W_DEF,
    parameter int unsigned X0     = 304,
    parameter int unsigned Y0     = 232
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pix_tick,
    input  logic [9:0]                 pixel_x,
    input  logic [9:0]                 pixel_y,
    input  logic                       video_on,
    input  logic                       R,
    input  logic                       G,
    input  logic                       B,
    text_row_scheduler_if.slave        host,
    output logic [CODE_W+ROW_BITS-1:0] rom_addr,
    input  logic [7:0]                 font_word,
    output logic                       busy,
    output logic                       r,
    output logic                       g,
    output logic                       b
);
    localparam int unsigned IW = (NCHARS > 1) ? $clog2(NCHARS) : 1;

    function automatic logic in_x_f(input logic [9:0] x);
        return (32'(x) >= X0) && (32'(x) < X0 + CELL_W * NCHARS);
    endfunction

    fsm_state_t           state;
    logic [ROW_BITS-1:0]  row_q;
    logic [CODE_W-1:0]    code_q;
    logic [7:0]           next_word;
    logic [7:0]           cur_word;
    logic                 in_y;
    logic [ROW_BITS-1:0]  row;
    logic [9:0]           rel_x;
    logic                 trigger;
    logic                 fetch_go;
    logic                 wr_commit;
    logic [IW-1:0]        fetch_idx;

    assign in_y  = (32'(pixel_y) >= Y0) && (32'(pixel_y) < Y0 + ROW_H);
    assign row   = font_row(pixel_y, 10'(Y0));

    // Offset from the slot preceding cell 0; a trigger lands on slot pixel 0.
    assign rel_x     = pixel_x - 10'(X0 - CELL_W);
    assign trigger   = pix_tick && in_y && (32'(pixel_x) >= X0 - CELL_W)
                       && (rel_x[2:0] == 3'd0) && (32'(rel_x) < CELL_W * NCHARS);
    assign fetch_idx = rel_x[IW+2:3];
    assign fetch_go  = trigger && (state == ST_IDLE);

    // Display read has priority; the wr_ack clk is skipped so a held wr_en
    // is not committed twice.
    assign wr_commit = host.wr_en && !host.wr_ack && (state != ST_RD_BUF) && !trigger;

    text_row_scheduler_char_buf #(
        .NCHARS (NCHARS),
        .CODE_W (CODE_W),
        .IW     (IW)
    ) u_char_buf (
        .clk     (clk),
        .rst     (rst),
        .we      (wr_commit),
        .wr_idx  (host.wr_idx),
        .wr_code (host.wr_code),
        .rd_en   (fetch_go),
        .rd_idx  (fetch_idx),
        .rd_code (code_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            host.wr_ack <= 1'b0;
        end else begin
            host.wr_ack <= wr_commit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            rom_addr  <= '0;
            row_q     <= '0;
            next_word <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (trigger) begin
                        state <= ST_RD_BUF;
                        busy  <= 1'b1;
                        row_q <= row;
                    end
                end
                ST_RD_BUF: begin
                    rom_addr <= {code_q, row_q};
                    state    <= ST_RD_ROM;
                end
                ST_RD_ROM: begin
                    state <= ST_LATCH;
                end
                ST_LATCH: begin
                    next_word <= font_word;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_word  <= '0;
            {r, g, b} <= 3'b000;
        end else if (pix_tick) begin
            if (pixel_x[2:0] == 3'd7) begin
                cur_word <= (in_y && in_x_f(pixel_x + 10'd1)) ? next_word : 8'h00;
            end
            {r, g, b} <= (video_on && in_y && in_x_f(pixel_x) && cur_word[3'd7 - pixel_x[2:0]])
                         ? {R, G, B} : 3'b000;
        end
    end
endmodule

// File: tb/tb_text_row_scheduler.sv
module tb_text_row_scheduler;
    localparam int N  = 8;
    localparam int X0 = 304;
    localparam int Y0 = 232;
    localparam int XE = X0 + 8 * N + 7;

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_tick;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       R, G, B;
    logic [5:0] rom_addr;
    logic [7:0] font_word;
    logic       busy;
    logic       r, g, b;

    int checks = 0;
    int errors = 0;
    logic [1:0] mbuf [N];

    text_row_scheduler_if #(.CODE_W(2)) host ();

    text_row_scheduler #(
        .NCHARS (N),
        .CODE_W (2),
        .X0     (X0),
        .Y0     (Y0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_tick  (pix_tick),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .video_on  (video_on),
        .R         (R),
        .G         (G),
        .B         (B),
        .host      (host),
        .rom_addr  (rom_addr),
        .font_word (font_word),
        .busy      (busy),
        .r         (r),
        .g         (g),
        .b         (b)
    );

    always #5 clk = ~clk;

    // Font ROM: code 0 is blank, other glyphs are an address hash.
    function automatic logic [7:0] font_rom(input logic [5:0] a);
        logic [15:0] p;
        if (a[5:4] == 2'd0) return 8'h00;
        p = 16'(a) * 16'd29;
        return p[7:0] ^ 8'hA5;
    endfunction

    always @(posedge clk) font_word <= font_rom(rom_addr);

    function automatic logic [2:0] exp_rgb(input int x, input int y, input logic von);
        int c;
        logic [7:0] w;
        if (!von || y < Y0 || y >= Y0 + 16 || x < X0 || x >= X0 + 8 * N) return 3'b000;
        c = (x - X0) / 8;
        w = font_rom({mbuf[c], 4'(y - Y0)});
        return w[7 - (x % 8)] ? {R, G, B} : 3'b000;
    endfunction

    task automatic tick_pixel(input int x, input int y, input logic von);
        logic [2:0] e;
        pixel_x = 10'(x); pixel_y = 10'(y); video_on = von; pix_tick = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pix_tick = 1'b0;
        e = exp_rgb(x, y, von);
        checks++;
        if ({r, g, b} !== e) begin
            errors++;
            $display("FAIL pixel x=%0d y=%0d: got %b expected %b", x, y, {r, g, b}, e);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic sweep(input int y, input logic von, input int x_lo, input int x_hi);
        for (int x = x_lo; x <= x_hi; x++) tick_pixel(x, y, von);
    endtask

    task automatic host_write(input logic [3:0] idx, input logic [1:0] code);
        int n;
        n = 0;
        host.wr_en = 1'b1; host.wr_idx = idx; host.wr_code = code;
        do begin
            @(negedge clk);
            n++;
        end while (!host.wr_ack && n < 8);
        checks++;
        if (host.wr_ack !== 1'b1 || n != 1) begin
            errors++;
            $display("FAIL write_ack idx=%0d: ack=%b after %0d clk, expected 1 after 1 clk", idx, host.wr_ack, n);
        end
        host.wr_en = 1'b0;
        @(negedge clk);
        checks++;
        if (host.wr_ack !== 1'b0) begin
            errors++;
            $display("FAIL write_ack_pulse idx=%0d: ack=%b expected 0", idx, host.wr_ack);
        end
    endtask

    task automatic check_rom_addr(input string name, input logic [5:0] e);
        checks++;
        if (rom_addr !== e) begin
            errors++;
            $display("FAIL %s: rom_addr=%0d expected %0d", name, rom_addr, e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({r, g, b, host.wr_ack, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: rgb/ack/busy=%b expected 00000", {r, g, b, host.wr_ack, busy});
        end
        check_rom_addr("reset_rom_addr", 6'd0);
    endtask

    task automatic test_blank_row();
        R = 1'b1; G = 1'b1; B = 1'b1;
        sweep(Y0, 1'b1, X0 - 16, XE);
        check_rom_addr("blank_rom_addr", 6'd0);
    endtask

    task automatic test_glyphs();
        host_write(4'd0, 2'd1); mbuf[0] = 2'd1;
        host_write(4'd1, 2'd2); mbuf[1] = 2'd2;
        host_write(4'd2, 2'd3); mbuf[2] = 2'd3;
        R = 1'b1; G = 1'b1; B = 1'b1;
        sweep(Y0 + 5, 1'b1, X0 - 16, XE);
        check_rom_addr("row5_rom_addr", {mbuf[N-1], 4'd5});
        R = 1'b1; G = 1'b0; B = 1'b1;
        sweep(Y0 + 15, 1'b1, X0 - 16, XE);
        check_rom_addr("row15_rom_addr", {mbuf[N-1], 4'd15});
    endtask

    task automatic test_outside();
        R = 1'b1; G = 1'b1; B = 1'b1;
        sweep(Y0 + 16, 1'b1, X0 - 16, XE);
        check_rom_addr("below_row_rom_addr", {mbuf[N-1], 4'd15});
        sweep(Y0 - 1, 1'b1, X0 - 16, XE);
        check_rom_addr("above_row_rom_addr", {mbuf[N-1], 4'd15});
        sweep(Y0 + 5, 1'b0, X0 - 16, XE);
        check_rom_addr("blanked_rom_addr", {mbuf[N-1], 4'd5});
    endtask

    task automatic test_write_race();
        int n;
        R = 1'b1; G = 1'b1; B = 1'b1;
        sweep(Y0 + 5, 1'b1, X0 - 16, X0 - 9);
        pixel_x = 10'(X0 - 8); pixel_y = 10'(Y0 + 5); video_on = 1'b1; pix_tick = 1'b1;
        host.wr_en = 1'b1; host.wr_idx = 4'd0; host.wr_code = 2'd3;
        @(posedge clk);
        @(negedge clk);
        pix_tick = 1'b0;
        checks++;
        if (host.wr_ack !== 1'b0) begin
            errors++;
            $display("FAIL race_ack_early: ack=%b expected 0", host.wr_ack);
        end
        n = 0;
        while (!host.wr_ack && n < 8) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (host.wr_ack !== 1'b1 || n != 2) begin
            errors++;
            $display("FAIL race_ack: ack=%b after %0d clk, expected 1 after 2 clk", host.wr_ack, n);
        end
        host.wr_en = 1'b0;
        @(negedge clk);
        checks++;
        if (host.wr_ack !== 1'b0) begin
            errors++;
            $display("FAIL race_ack_pulse: ack=%b expected 0", host.wr_ack);
        end
        sweep(Y0 + 5, 1'b1, X0 - 7, XE);
        mbuf[0] = 2'd3;
        sweep(Y0 + 5, 1'b1, X0 - 16, XE);
    endtask

    task automatic test_dropped_write();
        host_write(4'(N + 1), 2'd1);
        R = 1'b0; G = 1'b1; B = 1'b1;
        sweep(Y0 + 7, 1'b1, X0 - 16, XE);
    endtask

    task automatic test_reset_mid_fetch();
        logic [2:0] e;
        R = 1'b1; G = 1'b1; B = 1'b1;
        sweep(Y0 + 5, 1'b1, X0 - 16, X0 - 1);
        pixel_x = 10'(X0); pixel_y = 10'(Y0 + 5); video_on = 1'b1; pix_tick = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pix_tick = 1'b0;
        e = exp_rgb(X0, Y0 + 5, 1'b1);
        checks++;
        if ({r, g, b} !== e) begin
            errors++;
            $display("FAIL prereset_pixel: got %b expected %b", {r, g, b}, e);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL prereset_busy: busy=%b expected 1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, r, g, b} !== 4'b0) begin
            errors++;
            $display("FAIL midfetch_reset: busy/rgb=%b expected 0000", {busy, r, g, b});
        end
        check_rom_addr("midfetch_reset_rom_addr", 6'd0);
        for (int i = 0; i < N; i++) mbuf[i] = 2'd0;
        @(negedge clk);
        sweep(Y0 + 5, 1'b1, X0 - 16, XE);
        check_rom_addr("post_reset_rom_addr", 6'd5);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pix_tick = 1'b0; pixel_x = '0; pixel_y = '0; video_on = 1'b0;
        R = 1'b0; G = 1'b0; B = 1'b0;
        host.wr_en = 1'b0; host.wr_idx = '0; host.wr_code = '0;
        for (int i = 0; i < N; i++) mbuf[i] = 2'd0;
        @(negedge clk);
        test_reset();
        test_blank_row();
        test_glyphs();
        test_outside();
        test_write_race();
        test_dropped_write();
        test_reset_mid_fetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
